fb_write_arbiter: RTL and testbench

- Sole write-side controller for the 128x128, 6-bit dual-port framebuffer; drives its wr_addr/wr_en/wr_data port.
- Shares the write port between two pixel requesters (A: game logic, B: sprite/blitter) with round-robin arbitration.
- Contains a fill engine that clears the buffer to one colour at one pixel per clock.
- Read port is untouched; display scan-out keeps full read bandwidth.

---
 rtl/fb_write_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: sole write-side controller for the 128x128 x 6-bit
// framebuffer. Two pixel requesters (A: game logic, B: sprite/blitter) share
// the write port round-robin, and a fill engine can clear the buffer to a
// single colour at one pixel per clock. The read port is not touched here.
//
// Build option: define FB_RECT_FILL_EN to add rectangle bounds
// (fill_x0/fill_y0/fill_x1/fill_y1) to the fill engine. Without it every fill
// covers the whole buffer.
module fb_write_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 6,
  parameter int X_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
`ifdef FB_RECT_FILL_EN
  input  logic [X_W-1:0]    fill_x0,
  input  logic [X_W-1:0]    fill_y0,
  input  logic [X_W-1:0]    fill_x1,
  input  logic [X_W-1:0]    fill_y1,
`endif
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic              fb_wr_en,
  output logic [DATA_W-1:0] fb_wr_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_W-1:0] ONE_X = {{(X_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;

  // Remembers who won the last grant; 1 means B, so A wins the first tie.
  logic              last_grant_b;

  logic [DATA_W-1:0] color_q;
  logic [X_W-1:0]    cur_x;
  logic [X_W-1:0]    cur_y;

  logic [X_W-1:0]    rx0;
  logic [X_W-1:0]    ry0;
  logic [X_W-1:0]    rx1;
  logic [X_W-1:0]    ry1;

  logic              fill_empty;
  logic              fill_last;
  logic              grant_a;
  logic              grant_b;
  logic              fill_write;

`ifdef FB_RECT_FILL_EN
  logic [X_W-1:0]    x0_q;
  logic [X_W-1:0]    y0_q;
  logic [X_W-1:0]    x1_q;
  logic [X_W-1:0]    y1_q;

  assign rx0 = x0_q;
  assign ry0 = y0_q;
  assign rx1 = x1_q;
  assign ry1 = y1_q;
`else
  assign rx0 = '0;
  assign ry0 = '0;
  assign rx1 = '1;
  assign ry1 = '1;
`endif

  // An inverted rectangle produces no writes at all; the full-screen case
  // can never be empty.
  assign fill_empty = (rx0 > rx1) || (ry0 > ry1);
  assign fill_last  = (cur_x == rx1) && (cur_y == ry1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a fill runs until its last pixel, then one DONE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fill_start) begin
          next_state = FILL;
        end
      end
      FILL: begin
        if (fill_empty || fill_last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode: decides who owns the write port this cycle. A fill start
  // blocks both requesters; a tie goes to whoever did not win last time.
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    fill_write = 1'b0;
    if (state == IDLE && !fill_start) begin
      if (a_valid && b_valid) begin
        grant_a = last_grant_b;
        grant_b = !last_grant_b;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    if (state == FILL && !fill_empty) begin
      fill_write = 1'b1;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Registered write port; address and data hold while no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_wr_en     <= 1'b0;
      fb_wr_addr   <= '0;
      fb_wr_data   <= '0;
      last_grant_b <= 1'b1;
    end else begin
      fb_wr_en <= grant_a | grant_b | fill_write;
      if (grant_a) begin
        fb_wr_addr   <= a_addr;
        fb_wr_data   <= a_data;
        last_grant_b <= 1'b0;
      end else if (grant_b) begin
        fb_wr_addr   <= b_addr;
        fb_wr_data   <= b_data;
        last_grant_b <= 1'b1;
      end else if (fill_write) begin
        fb_wr_addr <= {cur_y, cur_x};
        fb_wr_data <= color_q;
      end
    end
  end

  // Fill engine: latch colour (and bounds) on start, then raster-scan x
  // fastest. In the full-screen case {cur_y, cur_x} is a plain 0..16383 count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
`ifdef FB_RECT_FILL_EN
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
`endif
    end else if (state == IDLE && fill_start) begin
      color_q <= fill_color;
`ifdef FB_RECT_FILL_EN
      cur_x   <= fill_x0;
      cur_y   <= fill_y0;
      x0_q    <= fill_x0;
      y0_q    <= fill_y0;
      x1_q    <= fill_x1;
      y1_q    <= fill_y1;
`else
      cur_x   <= '0;
      cur_y   <= '0;
`endif
    end else if (fill_write) begin
      if (cur_x == rx1) begin
        cur_x <= rx0;
        cur_y <= cur_y + ONE_X;
      end else begin
        cur_x <= cur_x + ONE_X;
      end
    end
  end

  // Status flags: busy mirrors the non-IDLE states, done pulses once after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_busy <= (next_state != IDLE);
      fill_done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed and randomized checks of fb_write_arbiter.
// Arbitration is predicted from the round-robin rule over pending requests;
// fills are predicted as a list of raster-order addresses.
module tb_fb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [13:0] a_addr;
  logic [5:0]  a_data;
  logic        b_valid;
  logic        b_ready;
  logic [13:0] b_addr;
  logic [5:0]  b_data;
  logic        fill_start;
  logic [5:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic [13:0] fb_wr_addr;
  logic        fb_wr_en;
  logic [5:0]  fb_wr_data;
`ifdef FB_RECT_FILL_EN
  logic [6:0]  fill_x0;
  logic [6:0]  fill_y0;
  logic [6:0]  fill_x1;
  logic [6:0]  fill_y1;
`endif

  int tests_run;
  int tests_failed;

  // Reference model state: pending request per requester, last winner,
  // and the last value written to the framebuffer port.
  logic        m_last_b;
  logic        pa_v;
  logic [13:0] pa_addr;
  logic [5:0]  pa_data;
  logic        pb_v;
  logic [13:0] pb_addr;
  logic [5:0]  pb_data;
  logic [13:0] m_prev_addr;
  logic [5:0]  m_prev_data;

  fb_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .fill_start (fill_start),
    .fill_color (fill_color),
`ifdef FB_RECT_FILL_EN
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_x1    (fill_x1),
    .fill_y1    (fill_y1),
`endif
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_data (fb_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [13:0] aa, input logic [5:0] ad,
                               input logic bv, input logic [13:0] ba, input logic [5:0] bd,
                               input logic fs, input logic [5:0] fc);
    a_valid    = av;
    a_addr     = aa;
    a_data     = ad;
    b_valid    = bv;
    b_addr     = ba;
    b_data     = bd;
    fill_start = fs;
    fill_color = fc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration cycle: present pending requests, predict the winner from
  // the round-robin rule, then check the registered write one cycle later.
  task automatic arbCycle(input string tag);
    logic exp_a;
    logic exp_b;
    applyStimulus(pa_v, pa_addr, pa_data, pb_v, pb_addr, pb_data, 1'b0, fill_color);
    #1;
    if (pa_v && pb_v) begin
      exp_a = m_last_b;
      exp_b = !m_last_b;
    end else begin
      exp_a = pa_v;
      exp_b = pb_v;
    end
    checkOutput({tag, "_a_ready"}, 32'(a_ready), 32'(exp_a));
    checkOutput({tag, "_b_ready"}, 32'(b_ready), 32'(exp_b));
    tick();
    if (exp_a) begin
      m_prev_addr = pa_addr;
      m_prev_data = pa_data;
      m_last_b    = 1'b0;
      pa_v        = 1'b0;
    end else if (exp_b) begin
      m_prev_addr = pb_addr;
      m_prev_data = pb_data;
      m_last_b    = 1'b1;
      pb_v        = 1'b0;
    end
    checkOutput({tag, "_wr_en"}, 32'(fb_wr_en), 32'(exp_a || exp_b));
    checkOutput({tag, "_wr_addr"}, 32'(fb_wr_addr), 32'(m_prev_addr));
    checkOutput({tag, "_wr_data"}, 32'(fb_wr_data), 32'(m_prev_data));
  endtask

  // Start a fill and check every cycle up to and including the fill_done pulse.
  task automatic fillRun(input string tag, input logic [5:0] color,
                         input int x0, input int y0, input int x1, input int y1);
    int q[$];
    int bad;
    if (x0 <= x1 && y0 <= y1) begin
      for (int y = y0; y <= y1; y++) begin
        for (int x = x0; x <= x1; x++) begin
          q.push_back(y * 128 + x);
        end
      end
    end
    fill_start = 1'b1;
    fill_color = color;
`ifdef FB_RECT_FILL_EN
    fill_x0 = 7'(x0);
    fill_y0 = 7'(y0);
    fill_x1 = 7'(x1);
    fill_y1 = 7'(y1);
`endif
    #1;
    checkOutput({tag, "_start_a_ready"}, 32'(a_ready), 32'(0));
    checkOutput({tag, "_start_b_ready"}, 32'(b_ready), 32'(0));
    tick();
    fill_start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(fill_busy), 32'(1));
    checkOutput({tag, "_no_write_at_start"}, 32'(fb_wr_en), 32'(0));
    bad = 0;
    for (int k = 0; k < q.size(); k++) begin
      tick();
      if (fb_wr_en !== 1'b1 || fb_wr_addr !== 14'(q[k]) || fb_wr_data !== color ||
          fill_busy !== 1'b1 || fill_done !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
        bad++;
      end
    end
    if (q.size() == 0) begin
      tick();
      if (fb_wr_en !== 1'b0 || fill_done !== 1'b0) begin
        bad++;
      end
    end
    checkOutput({tag, "_bad_write_cycles"}, 32'(bad), 32'(0));
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(fill_done), 32'(1));
    checkOutput({tag, "_done_wr_en"}, 32'(fb_wr_en), 32'(0));
  endtask

  initial begin
    int en_run;
    int done_seen;
    int en_seen;
    int guard;

    tests_run    = 0;
    tests_failed = 0;
    applyStimulus(1'b0, 14'h0, 6'h0, 1'b0, 14'h0, 6'h0, 1'b0, 6'h0);
`ifdef FB_RECT_FILL_EN
    fill_x0 = 7'd0;
    fill_y0 = 7'd0;
    fill_x1 = 7'd127;
    fill_y1 = 7'd127;
`endif
    pa_v        = 1'b0;
    pb_v        = 1'b0;
    pa_addr     = '0;
    pa_data     = '0;
    pb_addr     = '0;
    pb_data     = '0;
    m_last_b    = 1'b1;
    m_prev_addr = '0;
    m_prev_data = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_wr_en", 32'(fb_wr_en), 32'(0));
    checkOutput("reset_wr_addr", 32'(fb_wr_addr), 32'(0));
    checkOutput("reset_wr_data", 32'(fb_wr_data), 32'(0));
    checkOutput("reset_busy", 32'(fill_busy), 32'(0));
    checkOutput("reset_done", 32'(fill_done), 32'(0));
    checkOutput("reset_a_ready", 32'(a_ready), 32'(0));
    rst = 1'b0;

    // Both requesters continuously valid: A,B,A,B with no bubbles.
    en_run = 0;
    for (int i = 0; i < 4; i++) begin
      if (!pa_v) begin
        pa_v = 1'b1; pa_addr = 14'(16'h0100 + i); pa_data = 6'(i + 1);
      end
      if (!pb_v) begin
        pb_v = 1'b1; pb_addr = 14'(16'h0200 + i); pb_data = 6'(i + 33);
      end
      arbCycle("contend");
      en_run += int'(fb_wr_en);
    end
    checkOutput("contend_back_to_back", 32'(en_run), 32'(4));

    // Randomized request traffic held until accepted.
    for (int i = 0; i < 300; i++) begin
      if (!pa_v && $urandom_range(0, 2) != 0) begin
        pa_v = 1'b1; pa_addr = 14'($urandom); pa_data = 6'($urandom);
      end
      if (!pb_v && $urandom_range(0, 2) != 0) begin
        pb_v = 1'b1; pb_addr = 14'($urandom); pb_data = 6'($urandom);
      end
      arbCycle("rand");
    end
    guard = 0;
    while ((pa_v || pb_v) && guard < 4) begin
      arbCycle("drain");
      guard++;
    end
    checkOutput("drain_complete", 32'(pa_v || pb_v), 32'(0));

    // Asynchronous reset in the middle of a write stream.
    pa_v = 1'b1; pa_addr = 14'($urandom); pa_data = 6'($urandom);
    arbCycle("pre_reset");
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_wr_en", 32'(fb_wr_en), 32'(0));
    checkOutput("async_rst_wr_addr", 32'(fb_wr_addr), 32'(0));
    checkOutput("async_rst_wr_data", 32'(fb_wr_data), 32'(0));
    checkOutput("async_rst_busy", 32'(fill_busy), 32'(0));
    tick();
    applyStimulus(1'b0, 14'h0, 6'h0, 1'b0, 14'h0, 6'h0, 1'b0, 6'h0);
    rst = 1'b0;
    m_last_b    = 1'b1;
    m_prev_addr = '0;
    m_prev_data = '0;
    pa_v = 1'b1; pa_addr = 14'h0081; pa_data = 6'h2A;
    arbCycle("a_0081");

    // Full fill started in the same cycle as an A request.
    applyStimulus(1'b1, 14'h1234, 6'h33, 1'b0, 14'h0, 6'h0, 1'b0, 6'h0);
    fillRun("full_fill", 6'h15, 0, 0, 127, 127);
    checkOutput("a_after_fill_ready", 32'(a_ready), 32'(1));
    tick();
    applyStimulus(1'b0, 14'h0, 6'h0, 1'b0, 14'h0, 6'h0, 1'b0, 6'h0);
    checkOutput("a_after_fill_wr_en", 32'(fb_wr_en), 32'(1));
    checkOutput("a_after_fill_wr_addr", 32'(fb_wr_addr), 32'(14'h1234));
    checkOutput("a_after_fill_wr_data", 32'(fb_wr_data), 32'(6'h33));
    checkOutput("done_single_pulse", 32'(fill_done), 32'(0));
    checkOutput("busy_clear_after_fill", 32'(fill_busy), 32'(0));

    // Reset while the fill is writing pixel 100.
    applyStimulus(1'b0, 14'h0, 6'h0, 1'b0, 14'h0, 6'h0, 1'b1, 6'h2C);
    tick();
    fill_start = 1'b0;
    repeat (101) tick();
    checkOutput("fill_reached_100", 32'(fb_wr_addr), 32'(100));
    #3;
    rst = 1'b1;
    #1;
    checkOutput("fill_rst_wr_en", 32'(fb_wr_en), 32'(0));
    checkOutput("fill_rst_wr_addr", 32'(fb_wr_addr), 32'(0));
    checkOutput("fill_rst_busy", 32'(fill_busy), 32'(0));
    tick();
    rst = 1'b0;
    done_seen = 0;
    en_seen   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      done_seen += int'(fill_done);
      en_seen   += int'(fb_wr_en);
    end
    checkOutput("fill_rst_no_done", 32'(done_seen), 32'(0));
    checkOutput("fill_rst_no_writes", 32'(en_seen), 32'(0));
    m_last_b    = 1'b1;
    m_prev_addr = '0;
    m_prev_data = '0;
    pa_v = 1'b1; pa_addr = 14'h0ABC; pa_data = 6'h11;
    arbCycle("a_after_fill_rst");

`ifdef FB_RECT_FILL_EN
    fillRun("rect_fill", 6'h07, 2, 5, 3, 6);
    fillRun("empty_rect", 6'h09, 4, 5, 3, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
